ram_dump_reader: RTL and testbench

- Reads a contiguous byte range out of the scalar port of the data RAM after a program has run, and streams the bytes to a host-side transmitter over a valid/ready handshake.
- The CPU writes results into data RAM; this block is the reader at the other end of that path.
- It drives `cpu_hold` while active so the pipeline stays stalled and RAM port A is not contended.
- It sits beside the RAM and time-multiplexes port A with the CPU, selected by `busy`.

---
 rtl/ram_dump_reader_if.sv | 32 +++
 rtl/ram_dump_reader.sv | 126 ++++++++++++
 tb/tb_ram_dump_reader.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_dump_reader_if.sv
// Bus bundle between the dump reader, data RAM port A and the host-side
// byte transmitter. The reader is the master; the RAM/transmitter side is
// the slave.
interface ram_dump_reader_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_rden;
  logic [DATA_W-1:0] mem_q;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output mem_address,
    output mem_rden,
    output out_data,
    output out_valid,
    input  mem_q,
    input  out_ready
  );

  modport slave (
    input  mem_address,
    input  mem_rden,
    input  out_data,
    input  out_valid,
    output mem_q,
    output out_ready
  );
endinterface

// File: rtl/ram_dump_reader.sv
// Streams a contiguous byte range out of data RAM port A to a host-side
// transmitter over valid/ready, one byte per ISSUE/WAIT/PRESENT round.
// The CPU is held off RAM port A for as long as the block is busy.
module ram_dump_reader #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 8,
  parameter int LEN_W        = 13,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  ram_dump_reader_if.master bus,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic [LEN_W-1:0]  bytes_sent
);

  // Wide enough for READ_LATENCY up to 4.
  localparam int LAT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_PRESENT,
    ST_FINISH
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [LEN_W-1:0]  remaining_reg, remaining_next;
  logic [LEN_W-1:0]  sent_reg, sent_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic [LAT_W-1:0]  lat_reg, lat_next;

  // State and datapath registers; reset aborts any dump in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      sent_reg      <= '0;
      data_reg      <= '0;
      lat_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      remaining_reg <= remaining_next;
      sent_reg      <= sent_next;
      data_reg      <= data_next;
      lat_reg       <= lat_next;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    remaining_next = remaining_reg;
    sent_next      = sent_reg;
    data_next      = data_reg;
    lat_next       = lat_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          sent_next = '0;
          if (length != '0) begin
            addr_next      = base_addr;
            remaining_next = length;
            state_next     = ST_ISSUE;
          end else begin
            // Empty dump: report completion without touching RAM.
            state_next = ST_FINISH;
          end
        end
      end

      ST_ISSUE: begin
        lat_next   = LAT_W'(READ_LATENCY);
        state_next = ST_WAIT;
      end

      ST_WAIT: begin
        lat_next = lat_reg - LAT_W'(1);
        if (lat_reg == LAT_W'(1)) begin
          data_next  = bus.mem_q;
          state_next = ST_PRESENT;
        end
      end

      ST_PRESENT: begin
        if (bus.out_ready) begin
          sent_next      = sent_reg + LEN_W'(1);
          // Address wraps naturally at the top of the RAM.
          addr_next      = addr_reg + ADDR_W'(1);
          remaining_next = remaining_reg - LEN_W'(1);
          state_next     = (remaining_reg == LEN_W'(1)) ? ST_FINISH : ST_ISSUE;
        end
      end

      ST_FINISH: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are registers or pure state decodes, never input-combinational.
  assign bus.mem_address = addr_reg;
  assign bus.mem_rden    = (state_reg == ST_ISSUE);
  assign bus.out_data    = data_reg;
  assign bus.out_valid   = (state_reg == ST_PRESENT);
  assign busy            = (state_reg != ST_IDLE);
  assign cpu_hold        = busy;
  assign done            = (state_reg == ST_FINISH);
  assign bytes_sent      = sent_reg;

endmodule

// File: tb/tb_ram_dump_reader.sv
// Directed bench for ram_dump_reader: one instance at READ_LATENCY=1 for
// the functional cases, one at READ_LATENCY=2 for the full-RAM dump.
module tb_ram_dump_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start1, start2;
  logic [11:0] base1, base2;
  logic [12:0] len1, len2;
  logic        busy1, busy2, hold1, hold2, done1, done2;
  logic [12:0] sent1, sent2;

  ram_dump_reader_if #(.ADDR_W(12), .DATA_W(8)) bus1 ();
  ram_dump_reader_if #(.ADDR_W(12), .DATA_W(8)) bus2 ();

  ram_dump_reader #(.ADDR_W(12), .DATA_W(8), .LEN_W(13), .READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .base_addr(base1), .length(len1),
    .bus(bus1), .busy(busy1), .cpu_hold(hold1), .done(done1), .bytes_sent(sent1)
  );

  ram_dump_reader #(.ADDR_W(12), .DATA_W(8), .LEN_W(13), .READ_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .base_addr(base2), .length(len2),
    .bus(bus2), .busy(busy2), .cpu_hold(hold2), .done(done2), .bytes_sent(sent2)
  );

  always #5 clk = ~clk;

  // RAM model: registered read, one extra pipeline stage for the second port.
  logic [7:0] mem [0:4095];
  logic [7:0] q1, q2a, q2b;
  always @(posedge clk) begin
    q1  <= mem[bus1.mem_address];
    q2a <= mem[bus2.mem_address];
    q2b <= q2a;
  end
  assign bus1.mem_q = q1;
  assign bus2.mem_q = q2b;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Mid-cycle monitors: record handshakes and count strobes.
  logic [7:0]  data_q1[$], data_q2[$];
  logic [11:0] addr_q1[$], addr_q2[$];
  int          hs_cyc_q2[$];
  int rden_cnt1 = 0, done_cnt1 = 0, valid_cnt1 = 0, done_cnt2 = 0;
  always @(negedge clk) begin
    if (bus1.out_valid && bus1.out_ready) begin
      data_q1.push_back(bus1.out_data);
      addr_q1.push_back(bus1.mem_address);
    end
    if (bus2.out_valid && bus2.out_ready) begin
      data_q2.push_back(bus2.out_data);
      addr_q2.push_back(bus2.mem_address);
      hs_cyc_q2.push_back(cyc);
    end
    if (bus1.mem_rden)  rden_cnt1  <= rden_cnt1 + 1;
    if (done1)          done_cnt1  <= done_cnt1 + 1;
    if (bus1.out_valid) valid_cnt1 <= valid_cnt1 + 1;
    if (done2)          done_cnt2  <= done_cnt2 + 1;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // what: 0 = out_valid, 1 = done, 2 = dut1 handshake count reached tgt
  function automatic bit cond(input int sel, input int what, input int tgt);
    if (what == 0) return (sel == 1) ? bus1.out_valid : bus2.out_valid;
    if (what == 1) return (sel == 1) ? done1 : done2;
    return data_q1.size() >= tgt;
  endfunction

  task automatic wait_for(input int sel, input int what, input int tgt, input int max, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i <= max; i++) begin
      if (cond(sel, what, tgt)) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic check_idle1(input string tag);
    check({tag, "_addr"},  32'(bus1.mem_address), 32'h0);
    check({tag, "_data"},  32'(bus1.out_data),    32'h0);
    check({tag, "_valid"}, 32'(bus1.out_valid),   32'h0);
    check({tag, "_rden"},  32'(bus1.mem_rden),    32'h0);
    check({tag, "_busy"},  32'(busy1),            32'h0);
    check({tag, "_hold"},  32'(hold1),            32'h0);
    check({tag, "_done"},  32'(done1),            32'h0);
    check({tag, "_sent"},  32'(sent1),            32'h0);
  endtask

  initial begin
    int hq, dc, rc, vc, c0;

    for (int i = 0; i < 4096; i++) mem[i] = 8'((i * 37) + (i >> 8));
    mem[12'h010] = 8'hA1; mem[12'h011] = 8'hB2; mem[12'h012] = 8'hC3;
    mem[12'hFFE] = 8'h11; mem[12'hFFF] = 8'h22;
    mem[12'h000] = 8'h33; mem[12'h001] = 8'h44;

    reset = 1'b1;
    start1 = 1'b0; base1 = '0; len1 = '0; bus1.out_ready = 1'b0;
    start2 = 1'b0; base2 = '0; len2 = '0; bus2.out_ready = 1'b0;
    repeat (3) step();

    // Reset state
    check_idle1("rst1");
    check("rst2_busy",  32'(busy2), 32'h0);
    check("rst2_valid", 32'(bus2.out_valid), 32'h0);
    check("rst2_sent",  32'(sent2), 32'h0);
    reset = 1'b0;
    step();

    // Test 1: three bytes, transmitter always ready
    bus1.out_ready = 1'b1;
    hq = data_q1.size(); dc = done_cnt1;
    base1 = 12'h010; len1 = 13'd3; start1 = 1'b1; c0 = cyc;
    step();
    start1 = 1'b0;
    wait_for(1, 0, 0, 10, "t1_valid_timeout");
    check("t1_latency", 32'(cyc - c0), 32'd3);
    wait_for(1, 1, 0, 40, "t1_done_timeout");
    check("t1_busy_at_done", 32'(busy1), 32'h1);
    step();
    check("t1_busy_after", 32'(busy1), 32'h0);
    check("t1_hold_after", 32'(hold1), 32'h0);
    check("t1_sent", 32'(sent1), 32'd3);
    check("t1_done_cnt", 32'(done_cnt1 - dc), 32'd1);
    check("t1_count", 32'(data_q1.size() - hq), 32'd3);
    check("t1_d0", 32'(data_q1[hq]),   32'hA1);
    check("t1_d1", 32'(data_q1[hq+1]), 32'hB2);
    check("t1_d2", 32'(data_q1[hq+2]), 32'hC3);
    check("t1_a0", 32'(addr_q1[hq]),   32'h010);
    check("t1_a1", 32'(addr_q1[hq+1]), 32'h011);
    check("t1_a2", 32'(addr_q1[hq+2]), 32'h012);

    // Test 2: transmitter stalls during the second byte
    hq = data_q1.size();
    base1 = 12'h010; len1 = 13'd3; start1 = 1'b1;
    step();
    start1 = 1'b0;
    wait_for(1, 2, hq + 1, 20, "t2_first_timeout");
    bus1.out_ready = 1'b0;
    wait_for(1, 0, 0, 10, "t2_valid_timeout");
    rc = rden_cnt1;
    for (int i = 0; i < 5; i++) begin
      check("t2_stall_valid", 32'(bus1.out_valid),   32'h1);
      check("t2_stall_data",  32'(bus1.out_data),    32'hB2);
      check("t2_stall_addr",  32'(bus1.mem_address), 32'h011);
      step();
    end
    check("t2_no_rden", 32'(rden_cnt1 - rc), 32'd0);
    bus1.out_ready = 1'b1;
    wait_for(1, 1, 0, 40, "t2_done_timeout");
    step();
    check("t2_sent",  32'(sent1), 32'd3);
    check("t2_count", 32'(data_q1.size() - hq), 32'd3);
    check("t2_d1",    32'(data_q1[hq+1]), 32'hB2);
    check("t2_d2",    32'(data_q1[hq+2]), 32'hC3);

    // Test 3: address wrap at the top of RAM
    hq = data_q1.size();
    base1 = 12'hFFE; len1 = 13'd4; start1 = 1'b1;
    step();
    start1 = 1'b0;
    wait_for(1, 1, 0, 60, "t3_done_timeout");
    step();
    check("t3_sent",  32'(sent1), 32'd4);
    check("t3_count", 32'(data_q1.size() - hq), 32'd4);
    check("t3_a0", 32'(addr_q1[hq]),   32'hFFE);
    check("t3_a1", 32'(addr_q1[hq+1]), 32'hFFF);
    check("t3_a2", 32'(addr_q1[hq+2]), 32'h000);
    check("t3_a3", 32'(addr_q1[hq+3]), 32'h001);
    check("t3_d0", 32'(data_q1[hq]),   32'h11);
    check("t3_d1", 32'(data_q1[hq+1]), 32'h22);
    check("t3_d2", 32'(data_q1[hq+2]), 32'h33);
    check("t3_d3", 32'(data_q1[hq+3]), 32'h44);

    // Test 4: zero-length dump
    dc = done_cnt1; rc = rden_cnt1; vc = valid_cnt1;
    base1 = 12'h123; len1 = 13'd0; start1 = 1'b1;
    step();
    start1 = 1'b0;
    check("t4_done", 32'(done1), 32'h1);
    check("t4_busy", 32'(busy1), 32'h1);
    step();
    check("t4_done_after", 32'(done1), 32'h0);
    check("t4_busy_after", 32'(busy1), 32'h0);
    check("t4_sent", 32'(sent1), 32'd0);
    repeat (2) step();
    check("t4_no_rden",  32'(rden_cnt1 - rc),  32'd0);
    check("t4_no_valid", 32'(valid_cnt1 - vc), 32'd0);
    check("t4_done_cnt", 32'(done_cnt1 - dc),  32'd1);

    // Test 5: ignored start while busy, then reset mid-transfer
    hq = data_q1.size(); dc = done_cnt1;
    base1 = 12'h020; len1 = 13'd10; start1 = 1'b1;
    step();
    start1 = 1'b0;
    wait_for(1, 0, 0, 10, "t5_valid_timeout");
    base1 = 12'h100; len1 = 13'd5; start1 = 1'b1;
    step();
    start1 = 1'b0;
    wait_for(1, 2, hq + 2, 20, "t5_hs_timeout");
    reset = 1'b1;
    step();
    check_idle1("t5_reset");
    reset = 1'b0;
    repeat (3) step();
    check("t5_no_done", 32'(done_cnt1 - dc), 32'd0);
    check("t5_idle_valid", 32'(bus1.out_valid), 32'h0);
    check("t5_a0", 32'(addr_q1[hq]),   32'h020);
    check("t5_a1", 32'(addr_q1[hq+1]), 32'h021);
    hq = data_q1.size();
    base1 = 12'h000; len1 = 13'd1; start1 = 1'b1;
    step();
    start1 = 1'b0;
    wait_for(1, 1, 0, 20, "t5_done_timeout");
    step();
    check("t5_new_sent",  32'(sent1), 32'd1);
    check("t5_new_count", 32'(data_q1.size() - hq), 32'd1);
    check("t5_new_data",  32'(data_q1[hq]), 32'h33);
    check("t5_new_addr",  32'(addr_q1[hq]), 32'h000);

    // Test 6: full 4096-byte dump at READ_LATENCY=2
    bus2.out_ready = 1'b1;
    dc = done_cnt2;
    base2 = 12'h000; len2 = 13'h1000; start2 = 1'b1; c0 = cyc;
    step();
    start2 = 1'b0;
    wait_for(2, 0, 0, 10, "t6_valid_timeout");
    check("t6_latency", 32'(cyc - c0), 32'd4);
    wait_for(2, 1, 0, 4096 * 4 + 50, "t6_done_timeout");
    step();
    check("t6_sent", 32'(sent2), 32'd4096);
    check("t6_busy_after", 32'(busy2), 32'h0);
    check("t6_done_cnt", 32'(done_cnt2 - dc), 32'd1);
    check("t6_count", 32'(data_q2.size()), 32'd4096);
    if (data_q2.size() == 4096) begin
      for (int i = 0; i < 4096; i++) begin
        check("t6_addr", 32'(addr_q2[i]), 32'(i));
        check("t6_data", 32'(data_q2[i]), 32'(mem[i]));
        if (i > 0) check("t6_spacing", 32'(hs_cyc_q2[i] - hs_cyc_q2[i-1]), 32'd4);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
